// File: rtl/aud_player.sv
// aud_player: plays samples from an asynchronous-read sample memory as
// MSB-first serial DAC data. Each word is aligned to the DAC LR clock.
// Optional feature: define AUD_PLAYER_STEREO_EN to repeat each sample on
// the right channel. Without it, the right channel carries zeros.
module aud_player #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_dacdat,
    output logic              o_playing,
    output logic              o_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, PAUSED, WAIT_LRC, SEND} state_t;

    state_t            state, state_nxt;
    logic              lrc_p;
    logic              lrc_fall, lrc_rise;
    logic [DATA_W-1:0] shift_r, sample_r;
    logic [ADDR_W-1:0] end_r;
    logic [CNT_W-1:0]  bit_cnt;
    logic              load_left, load_right;
    logic              addr_clr, addr_inc, end_load, done_nxt, word_end;
`ifdef AUD_PLAYER_STEREO_EN
    logic              right_r, right_nxt;
`endif

    assign lrc_fall = lrc_p & ~i_lrc;
    assign lrc_rise = ~lrc_p & i_lrc;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: stop beats pause beats start; word end decides done/advance
    always_comb begin
        state_nxt  = state;
        load_left  = 1'b0;
        load_right = 1'b0;
        addr_clr   = 1'b0;
        addr_inc   = 1'b0;
        end_load   = 1'b0;
        done_nxt   = 1'b0;
        word_end   = 1'b0;
`ifdef AUD_PLAYER_STEREO_EN
        right_nxt  = right_r;
`endif
        if (i_stop) begin
            state_nxt = IDLE;
            addr_clr  = 1'b1;
        end else if (i_pause && (state == WAIT_LRC || state == SEND)) begin
            state_nxt = PAUSED;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state_nxt = WAIT_LRC;
                        addr_clr  = 1'b1;
                        end_load  = 1'b1;
                    end
                end
                PAUSED: begin
                    if (i_start) state_nxt = WAIT_LRC;
                end
                WAIT_LRC: begin
`ifdef AUD_PLAYER_STEREO_EN
                    if (right_r) begin
                        if (lrc_rise) begin
                            load_right = 1'b1;
                            state_nxt  = SEND;
                        end
                    end else if (lrc_fall) begin
                        load_left = 1'b1;
                        state_nxt = SEND;
                    end
`else
                    if (lrc_fall) begin
                        load_left = 1'b1;
                        state_nxt = SEND;
                    end
`endif
                end
                SEND: begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef AUD_PLAYER_STEREO_EN
                        if (!right_r) begin
                            right_nxt = 1'b1;
                            state_nxt = WAIT_LRC;
                        end else begin
                            right_nxt = 1'b0;
                            word_end  = 1'b1;
                        end
`else
                        word_end = 1'b1;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (word_end) begin
                if (o_address == end_r) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    addr_inc  = 1'b1;
                    state_nxt = WAIT_LRC;
                end
            end
        end
`ifdef AUD_PLAYER_STEREO_EN
        // Any abort restarts the frame on the left channel
        if (state_nxt == IDLE || state_nxt == PAUSED) right_nxt = 1'b0;
`endif
    end

    // Outputs decoded from state; reset forces IDLE so data stops asynchronously
    always_comb begin
        o_playing = (state == WAIT_LRC) || (state == SEND);
        o_dacdat  = (state == SEND) ? shift_r[DATA_W-1] : 1'b0;
    end

    // Datapath: LRC history, shift register, address, end latch, done pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lrc_p     <= 1'b0;
            shift_r   <= '0;
            sample_r  <= '0;
            end_r     <= '0;
            bit_cnt   <= '0;
            o_address <= '0;
            o_done    <= 1'b0;
        end else begin
            lrc_p  <= i_lrc;
            o_done <= done_nxt;
            if (load_left) begin
                shift_r  <= i_rdata;
                sample_r <= i_rdata;
                bit_cnt  <= '0;
            end else if (load_right) begin
                shift_r <= sample_r;
                bit_cnt <= '0;
            end else if (state == SEND) begin
                shift_r <= shift_r << 1;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (addr_clr)      o_address <= '0;
            else if (addr_inc) o_address <= o_address + ADDR_W'(1);
            if (end_load) end_r <= i_end_addr;
        end
    end

`ifdef AUD_PLAYER_STEREO_EN
    // Channel phase: set after the left word, cleared after the right word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) right_r <= 1'b0;
        else       right_r <= right_nxt;
    end
`endif

endmodule
